// File: rtl/look_ahead_adder_pkg.sv
// Shared constants for the two-level carry-lookahead adder.
// Group width is fixed at 4; the group count derives from the operand width.
package look_ahead_adder_pkg;

    localparam int CLA_GROUP_W   = 4;
    localparam int DEFAULT_WIDTH = 8;
    localparam int CLA_GROUP_CNT = DEFAULT_WIDTH / CLA_GROUP_W;

    function automatic int group_count(input int width);
        return width / CLA_GROUP_W;
    endfunction

endpackage

// File: rtl/look_ahead_adder_cla_group4.sv
// 4-bit carry-lookahead group: sum plus group generate/propagate.
// Purely combinational, zero latency; no flow control.
// gg/gp depend only on a/b so the second-level carry logic never loops back through cin.
module cla_group4
    import look_ahead_adder_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   cin,
    output logic [CLA_GROUP_W-1:0] sum,
    output logic                   gg,
    output logic                   gp
);

    logic [CLA_GROUP_W-1:0] g;
    logic [CLA_GROUP_W-1:0] p;
    logic [CLA_GROUP_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p and cin.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

endmodule

// File: rtl/look_ahead_adder.sv
// Registered two-level carry-lookahead adder: {outc,out} = ina + inb + inc.
// Latency 1 clock, throughput 1/cycle, no backpressure; out/outc hold when in_valid=0.
// Define LOOK_AHEAD_ADDER_OVF_EN to add the registered signed-overflow port ovf.
module look_ahead_adder
    import look_ahead_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ina,
    input  logic [WIDTH-1:0] inb,
    input  logic             inc,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             outc,
    output logic             out_valid
`ifdef LOOK_AHEAD_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = group_count(WIDTH);

    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;
    logic             vld_q;
    logic             carry_term;
    logic             prod;

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .a   (ina[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .b   (inb[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .cin (grp_c[k]),
            .sum (sum_d[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .gg  (gg[k]),
            .gp  (gp[k])
        );
    end

    // Second level: each group carry is its own sum of products over gg/gp/inc,
    // so no carry is built from a neighbouring group's carry.
    always_comb begin
        grp_c      = '0;
        carry_term = 1'b0;
        prod       = 1'b0;
        grp_c[0]   = inc;
        for (int k = 1; k <= NG; k++) begin
            carry_term = inc;
            for (int j = 0; j < k; j++) begin
                carry_term = carry_term & gp[j];
            end
            for (int j = 0; j < k; j++) begin
                prod = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    prod = prod & gp[m];
                end
                carry_term = carry_term | prod;
            end
            grp_c[k] = carry_term;
        end
    end

    assign cout_d = grp_c[NG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign out       = sum_q;
    assign outc      = cout_q;
    assign out_valid = vld_q;

`ifdef LOOK_AHEAD_ADDER_OVF_EN
    logic c_msb;
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB recovered from the MSB sum bit: s = p ^ c.
    assign c_msb = ina[WIDTH-1] ^ inb[WIDTH-1] ^ sum_d[WIDTH-1];
    assign ovf_d = cout_d ^ c_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_look_ahead_adder.sv
// Directed-vector bench for look_ahead_adder (WIDTH=8), with hand-computed expectations.
module tb_look_ahead_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] ina = '0;
    logic [W-1:0] inb = '0;
    logic         inc = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] out;
    logic         outc;
    logic         out_valid;
`ifdef LOOK_AHEAD_ADDER_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    look_ahead_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ina       (ina),
        .inb       (inb),
        .inc       (inc),
        .in_valid  (in_valid),
        .out       (out),
        .outc      (outc),
        .out_valid (out_valid)
`ifdef LOOK_AHEAD_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic v);
        @(negedge clk);
        ina      = a;
        inb      = b;
        inc      = c;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] s,
                           input logic co, input logic v);
        chk({tag, "_out"},  32'(out),       32'(s));
        chk({tag, "_outc"}, 32'(outc),      32'(co));
        chk({tag, "_vld"},  32'(out_valid), 32'(v));
    endtask

    initial begin
        // Reset asserted from time zero, before any clock edge.
        #2;
        chk_res("reset", 8'd0, 1'b0, 1'b0);
`ifdef LOOK_AHEAD_ADDER_OVF_EN
        chk("reset_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        drive(8'd10, 8'd15, 1'b0, 1'b1);
        chk_res("add10_15", 8'd25, 1'b0, 1'b1);

        drive(8'd210, 8'd199, 1'b0, 1'b1);
        chk_res("add210_199", 8'd153, 1'b1, 1'b1);
`ifdef LOOK_AHEAD_ADDER_OVF_EN
        chk("ovf210_199", 32'(ovf), 32'd0);
`endif
        drive(8'd210, 8'd199, 1'b1, 1'b1);
        chk_res("add210_199_c", 8'd154, 1'b1, 1'b1);

        drive(8'd255, 8'd0, 1'b1, 1'b1);
        chk_res("wrap255_0_c", 8'd0, 1'b1, 1'b1);

        drive(8'd255, 8'd255, 1'b1, 1'b1);
        chk_res("wrap255_255_c", 8'd255, 1'b1, 1'b1);

        drive(8'd127, 8'd1, 1'b0, 1'b1);
        chk_res("add127_1", 8'd128, 1'b0, 1'b1);
`ifdef LOOK_AHEAD_ADDER_OVF_EN
        chk("ovf127_1", 32'(ovf), 32'd1);
`endif

        // Three back-to-back operand sets on consecutive edges.
        drive(8'd100, 8'd50, 1'b1, 1'b1);
        chk_res("b2b_0", 8'd151, 1'b0, 1'b1);
        drive(8'd200, 8'd100, 1'b0, 1'b1);
        chk_res("b2b_1", 8'd44, 1'b1, 1'b1);
        drive(8'd17, 8'd34, 1'b1, 1'b1);
        chk_res("b2b_2", 8'd52, 1'b0, 1'b1);

        // Idle cycle with different operands present: result holds.
        drive(8'd240, 8'd240, 1'b1, 1'b0);
        chk_res("hold", 8'd52, 1'b0, 1'b0);

        // Cross-group carry chain: 0x0F + 0x01 ripples only via second level.
        drive(8'd15, 8'd0, 1'b1, 1'b1);
        chk_res("grp_carry", 8'd16, 1'b0, 1'b1);

        // Mid-stream reset between edges while out=153.
        drive(8'd210, 8'd199, 1'b0, 1'b1);
        chk_res("pre_rst", 8'd153, 1'b1, 1'b1);
        @(negedge clk);
        ina      = 8'd5;
        inb      = 8'd6;
        inc      = 1'b0;
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_res("async_rst", 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_res("rst_discard", 8'd0, 1'b0, 1'b0);
`ifdef LOOK_AHEAD_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst      = 1'b0;
        ina      = 8'd7;
        inb      = 8'd8;
        inc      = 1'b1;
        in_valid = 1'b1;
        #1;
        chk_res("post_release", 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_res("first_after_rst", 8'd16, 1'b0, 1'b1);

        drive(8'd0, 8'd0, 1'b0, 1'b0);
        chk_res("final_hold", 8'd16, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
